alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute-stage sequencer that sits directly upstream of the 8-bit ALU (ports i_s1, i_s2, i_en, i_func → o_result, o_zero, o_negative, o_overflow).
- Accepts one decoded instruction at a time over a valid/ready handshake and reads operands from an internal 8x8 register file.
- Drives the ALU, then captures the result and flags and writes back to the register file.
- Provides the SISD core with a sticky status (flags) register and a debug read port.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- REG_CNT, 8, number of registers; address width is clog2(REG_CNT) = 3.
- FUNC_W, 3, ALU function code width.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  decoded instruction present.
- o_ready  out  1  stage can accept an instruction.
- i_func  in  FUNC_W  ALU function code.
- i_rd  in  3  destination register.
- i_rs1  in  3  source register 1.
- i_rs2  in  3  source register 2.
- i_use_imm  in  1  when 1, operand 2 is i_imm instead of reg[i_rs2].
- i_imm  in  DATA_W  immediate value.
- o_alu_s1  out  DATA_W  to ALU i_s1.
- o_alu_s2  out  DATA_W  to ALU i_s2.
- o_alu_en  out  1  to ALU i_en.
- o_alu_func  out  FUNC_W  to ALU i_func.
- i_alu_result  in  DATA_W  from ALU o_result.
- i_alu_zero  in  1  from ALU o_zero.
- i_alu_negative  in  1  from ALU o_negative.
- i_alu_overflow  in  1  from ALU o_overflow.
- o_flags  out  3  status register {V,N,Z}.
- o_done  out  1  one-cycle pulse when an instruction retires.
- o_wb_we  out  1  qualifies o_done: 1 if a register was written.
- o_wb_addr  out  3  written register address.
- o_wb_data  out  DATA_W  written value.
- i_dbg_addr  in  3  debug read address.
- o_dbg_data  out  DATA_W  combinational read of reg[i_dbg_addr]; r0 reads 0.

Behaviour:
- Reset (async assert, sync use after deassert):
  - State = IDLE; all registers = 0; o_flags = 0.
  - o_done, o_wb_we, o_alu_en = 0; o_alu_s1/s2/func = 0; o_wb_addr/data = 0.
- FSM states: IDLE, FETCH, EXEC, WB.
- IDLE: o_ready = 1. On i_valid && o_ready, latch func, rd, rs1, rs2, use_imm, imm, then → FETCH. o_ready = 0 in all other states.
- FETCH:
  - Register o_alu_s1 = reg[rs1].
  - Register o_alu_s2 = use_imm ? imm : reg[rs2].
  - Register o_alu_func = func; o_alu_en = 1. → EXEC.
- EXEC:
  - ALU is combinational; sample i_alu_result and flags into holding registers; o_alu_en = 0 on exit. → WB.
  - o_alu_s1/s2/func hold their values until the next FETCH.
- WB:
  - o_done = 1 for exactly this cycle.
  - If func != FUNC_NOP: o_flags <= {ovf, neg, zero} and o_wb_data = result.
  - If additionally rd != 0: reg[rd] written at the end of this cycle, o_wb_we = 1, o_wb_addr = rd.
  - If func == FUNC_NOP: flags unchanged, o_wb_we = 0. → IDLE.
- Latency:
  - Handshake edge = cycle 0; o_done in cycle 3.
  - Next accept possible in cycle 4; throughput is 1 instruction per 4 cycles.
- r0 reads as 0 and ignores writes. Flags still update for a rd = 0 instruction (compare-style use).
- Hazards: none. A back-to-back dependent instruction is fetched after the WB write completes, so it sees the new value.
- Arithmetic: no width growth. Overflow is the ALU's carry-out, taken verbatim; this stage does no arithmetic.
- i_valid while not ready: ignored. Upstream holds the instruction until the o_ready handshake.
- Reset mid-operation: the in-flight instruction is abandoned, with no write, no flag update and no o_done.
- o_dbg_data reflects a write starting the cycle after WB.

Decomposition:
- Package alu_pkg holds:
  - DATA_W, FUNC_W;
  - function codes FUNC_NOP = 3'b000, FUNC_ADD = 3'b001;
  - state encoding (IDLE/FETCH/EXEC/WB, 2 bits);
  - flag bit indices FLAG_Z = 0, FLAG_N = 1, FLAG_V = 2.
- One sub-module, regfile_8x8: async-reset 8x8 registers, two combinational read ports plus a debug read port, one synchronous write port, r0 hardwired to 0.
- The ALU itself is instantiated outside, in the bench or core.

Test Plan:
- Reset: deassert i_rst_n mid-FETCH after loading r1 = 5 → all registers 0, o_flags = 0, o_ready = 1, no o_done.
- Immediate load: ADD rd = 1, rs1 = 0, imm = 8'h2A, use_imm = 1 → o_done in cycle 3, o_wb_we = 1, o_wb_addr = 1, o_wb_data = 8'h2A, o_dbg_data(1) = 8'h2A, flags = 3'b000.
- Overflow: r1 = 8'hFF, r2 = 8'h01, ADD rd = 3, rs1 = 1, rs2 = 2 → r3 = 8'h00, flags {V,N,Z} = 3'b101.
- r0 destination: ADD rd = 0, r1 + r1 with r1 = 8'h80 → o_wb_we = 0, r0 reads 0, flags = 3'b101.
- Back-to-back dependency: ADD r4 = r1 + imm 1 (r1 = 8'h10), immediately ADD r5 = r4 + r4 with i_valid held → r5 = 8'h22. Check o_ready low for cycles 1–3 and the second accept in cycle 4.
- NOP and stalls: func 000 with prior flags 3'b101 → o_done pulse, o_wb_we = 0, flags stay 3'b101. i_valid toggling while busy is never accepted twice.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, function codes, FSM states and flag indices for the ALU execute stage
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int FUNC_W  = 3;
    localparam int REG_CNT = 8;
    localparam int ADDR_W  = $clog2(REG_CNT);

    localparam logic [FUNC_W-1:0] FUNC_NOP = 3'b000;
    localparam logic [FUNC_W-1:0] FUNC_ADD = 3'b001;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic              use_imm;
        logic [DATA_W-1:0] imm;
    } instr_t;

    // Assemble the {V,N,Z} status word from the individual ALU flags.
    function automatic logic [2:0] pack_flags(input logic zero, input logic neg, input logic ovf);
        logic [2:0] f;
        f         = '0;
        f[FLAG_Z] = zero;
        f[FLAG_N] = neg;
        f[FLAG_V] = ovf;
        return f;
    endfunction

endpackage

// File: rtl/regfile_8x8.sv
// rtl/regfile_8x8.sv - 8x8 register file, two operand read ports, debug read port, one write port
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset (clears all registers)
//   i_we/i_waddr/i_wdata  synchronous write port; writes to r0 are dropped
//   i_raddr_a/o_rdata_a   combinational operand read port A
//   i_raddr_b/o_rdata_b   combinational operand read port B
//   i_dbg_addr/o_dbg_data combinational debug read port
//   r0 always reads as zero on every port.
module regfile_8x8
    import alu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] regs [0:REG_CNT-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            regs[i_waddr] <= i_wdata;
        end
    end

    // The address-zero guard keeps r0 at zero even if storage for it exists.
    assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : regs[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : regs[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : regs[i_dbg_addr];

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute-stage sequencer driving an external 8-bit ALU with register writeback
//
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_valid/o_ready                    instruction handshake (accept only in IDLE)
//   i_func,i_rd,i_rs1,i_rs2,
//   i_use_imm,i_imm                    decoded instruction fields
//   o_alu_s1,o_alu_s2,o_alu_en,
//   o_alu_func                         registered operands/control to the ALU
//   i_alu_result,i_alu_zero,
//   i_alu_negative,i_alu_overflow      combinational ALU results
//   o_flags                            sticky status {V,N,Z}
//   o_done,o_wb_we,o_wb_addr,o_wb_data retire pulse and writeback info
//   i_dbg_addr/o_dbg_data              debug register read
//
// One instruction every four cycles: IDLE(accept) -> FETCH -> EXEC -> WB.
module alu_exec_stage
    import alu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [FUNC_W-1:0] i_func,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    input  logic              i_use_imm,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_alu_s1,
    output logic [DATA_W-1:0] o_alu_s2,
    output logic              o_alu_en,
    output logic [FUNC_W-1:0] o_alu_func,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_zero,
    input  logic              i_alu_negative,
    input  logic              i_alu_overflow,
    output logic [2:0]        o_flags,
    output logic              o_done,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    state_t            state_q;
    state_t            state_d;
    instr_t            instr_q;
    logic [DATA_W-1:0] result_q;
    logic [2:0]        alu_flags_q;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              retire_alu;
    logic              rf_we;

    regfile_8x8 u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_we       (rf_we),
        .i_waddr    (instr_q.rd),
        .i_wdata    (result_q),
        .i_raddr_a  (instr_q.rs1),
        .o_rdata_a  (rs1_data),
        .i_raddr_b  (instr_q.rs2),
        .o_rdata_b  (rs2_data),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_valid) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operands are read in FETCH, so a dependent instruction accepted right
    // after WB already sees the written value; no forwarding is needed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instr_q     <= '0;
            o_alu_s1    <= '0;
            o_alu_s2    <= '0;
            o_alu_func  <= '0;
            o_alu_en    <= 1'b0;
            result_q    <= '0;
            alu_flags_q <= '0;
            o_flags     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        instr_q.func    <= i_func;
                        instr_q.rd      <= i_rd;
                        instr_q.rs1     <= i_rs1;
                        instr_q.rs2     <= i_rs2;
                        instr_q.use_imm <= i_use_imm;
                        instr_q.imm     <= i_imm;
                    end
                end
                ST_FETCH: begin
                    o_alu_s1   <= rs1_data;
                    o_alu_s2   <= instr_q.use_imm ? instr_q.imm : rs2_data;
                    o_alu_func <= instr_q.func;
                    o_alu_en   <= 1'b1;
                end
                ST_EXEC: begin
                    result_q    <= i_alu_result;
                    alu_flags_q <= pack_flags(i_alu_zero, i_alu_negative, i_alu_overflow);
                    o_alu_en    <= 1'b0;
                end
                ST_WB: begin
                    // Flags update even when rd is r0 so compares still work.
                    if (retire_alu) begin
                        o_flags <= alu_flags_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_ready    = (state_q == ST_IDLE);
        o_done     = (state_q == ST_WB);
        retire_alu = o_done && (instr_q.func != FUNC_NOP);
        rf_we      = retire_alu && (instr_q.rd != '0);
        o_wb_we    = rf_we;
        o_wb_addr  = rf_we ? instr_q.rd : '0;
        o_wb_data  = retire_alu ? result_q : '0;
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage with a behavioural ALU
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid;
    logic              ready;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] rd, rs1, rs2;
    logic              use_imm;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_s1, alu_s2;
    logic              alu_en;
    logic [FUNC_W-1:0] alu_func;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero, alu_negative, alu_overflow;
    logic [2:0]        flags;
    logic              done;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    int total = 0;
    int bad   = 0;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] cap_s1, cap_s2;
    int                done_cnt;

    always #5 clk = ~clk;

    // Reference ALU: ADD with carry-out as overflow, anything else yields 0.
    logic [DATA_W:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        if (alu_func == FUNC_ADD) alu_sum = {1'b0, alu_s1} + {1'b0, alu_s2};
        alu_result   = alu_sum[DATA_W-1:0];
        alu_zero     = (alu_sum[DATA_W-1:0] == '0);
        alu_negative = alu_sum[DATA_W-1];
        alu_overflow = alu_sum[DATA_W];
    end

    alu_exec_stage dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (valid),
        .o_ready        (ready),
        .i_func         (func),
        .i_rd           (rd),
        .i_rs1          (rs1),
        .i_rs2          (rs2),
        .i_use_imm      (use_imm),
        .i_imm          (imm),
        .o_alu_s1       (alu_s1),
        .o_alu_s2       (alu_s2),
        .o_alu_en       (alu_en),
        .o_alu_func     (alu_func),
        .i_alu_result   (alu_result),
        .i_alu_zero     (alu_zero),
        .i_alu_negative (alu_negative),
        .i_alu_overflow (alu_overflow),
        .o_flags        (flags),
        .o_done         (done),
        .o_wb_we        (wb_we),
        .o_wb_addr      (wb_addr),
        .o_wb_data      (wb_data),
        .i_dbg_addr     (dbg_addr),
        .o_dbg_data     (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic drive(input logic [FUNC_W-1:0] f, input logic [ADDR_W-1:0] d,
                         input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                         input logic ui, input logic [DATA_W-1:0] im);
        func = f; rd = d; rs1 = a; rs2 = b; use_imm = ui; imm = im;
    endtask

    // Full 4-cycle instruction with cycle-by-cycle handshake/timing checks.
    task automatic run(input string tag, input logic [FUNC_W-1:0] f, input logic [ADDR_W-1:0] d,
                       input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic ui, input logic [DATA_W-1:0] im);
        chk({tag, ".ready_c0"}, ready, 1'b1);
        drive(f, d, a, b, ui, im);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk({tag, ".ready_c1"}, ready, 1'b0);
        chk({tag, ".done_c1"}, done, 1'b0);
        tick();
        chk({tag, ".done_c2"}, done, 1'b0);
        chk({tag, ".alu_en_c2"}, alu_en, 1'b1);
        cap_s1 = alu_s1;
        cap_s2 = alu_s2;
        tick();
        chk({tag, ".done_c3"}, done, 1'b1);
        chk({tag, ".ready_c3"}, ready, 1'b0);
        cap_we   = wb_we;
        cap_addr = wb_addr;
        cap_data = wb_data;
        tick();
        chk({tag, ".done_c4"}, done, 1'b0);
        chk({tag, ".ready_c4"}, ready, 1'b1);
        chk({tag, ".alu_en_c4"}, alu_en, 1'b0);
    endtask

    task automatic load(input string tag, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
        run(tag, FUNC_ADD, d, 3'd0, 3'd0, 1'b1, v);
        chk({tag, ".we"}, cap_we, 1'b1);
        chk({tag, ".data"}, cap_data, v);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; dbg_addr = '0;
        drive(FUNC_NOP, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst.ready", ready, 1'b1);
        chk("rst.flags", flags, 3'b000);
        chk("rst.done", done, 1'b0);
        chk("rst.wb_we", wb_we, 1'b0);
        chk("rst.alu_en", alu_en, 1'b0);
        chk("rst.alu_s1", alu_s1, 8'h00);
        dbg_chk("rst.r5", 3'd5, 8'h00);

        // Immediate load r1 = r0 + 0x2A
        run("imm", FUNC_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h2A);
        chk("imm.s1", cap_s1, 8'h00);
        chk("imm.s2", cap_s2, 8'h2A);
        chk("imm.we", cap_we, 1'b1);
        chk("imm.addr", cap_addr, 3'd1);
        chk("imm.data", cap_data, 8'h2A);
        dbg_chk("imm.r1", 3'd1, 8'h2A);
        chk("imm.flags", flags, 3'b000);

        // Overflow: 0xFF + 0x01
        load("ovf.ld1", 3'd1, 8'hFF);
        chk("ovf.ld1.flags", flags, 3'b010);
        load("ovf.ld2", 3'd2, 8'h01);
        run("ovf", FUNC_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
        chk("ovf.s1", cap_s1, 8'hFF);
        chk("ovf.s2", cap_s2, 8'h01);
        chk("ovf.we", cap_we, 1'b1);
        chk("ovf.addr", cap_addr, 3'd3);
        chk("ovf.data", cap_data, 8'h00);
        chk("ovf.flags", flags, 3'b101);
        dbg_chk("ovf.r3", 3'd3, 8'h00);
        chk("ovf.s1_hold", alu_s1, 8'hFF);

        // r0 destination: 0x80 + 0x80 into r0
        load("r0.ld", 3'd1, 8'h80);
        chk("r0.ld.flags", flags, 3'b010);
        run("r0", FUNC_ADD, 3'd0, 3'd1, 3'd1, 1'b0, 8'h00);
        chk("r0.we", cap_we, 1'b0);
        chk("r0.data", cap_data, 8'h00);
        chk("r0.flags", flags, 3'b101);
        dbg_chk("r0.r0", 3'd0, 8'h00);

        // NOP with i_valid toggling while busy
        drive(FUNC_NOP, 3'd6, 3'd1, 3'd1, 1'b1, 8'h55);
        valid = 1'b1;
        tick();
        drive(FUNC_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 8'h77);
        chk("nop.ready_c1", ready, 1'b0);
        tick();
        valid = 1'b0;
        chk("nop.done_c2", done, 1'b0);
        tick();
        valid = 1'b1;
        chk("nop.done_c3", done, 1'b1);
        chk("nop.we_c3", wb_we, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        tick();
        chk("nop.flags", flags, 3'b101);
        chk("nop.ready_c4", ready, 1'b1);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("nop.no_extra_done", done_cnt, 0);
        dbg_chk("nop.r6", 3'd6, 8'h00);

        // Back-to-back dependent instructions, i_valid held
        load("b2b.ld", 3'd1, 8'h10);
        drive(FUNC_ADD, 3'd4, 3'd1, 3'd0, 1'b1, 8'h01);
        valid = 1'b1;
        tick();
        drive(FUNC_ADD, 3'd5, 3'd4, 3'd4, 1'b0, 8'h00);
        chk("b2b.ready_c1", ready, 1'b0);
        tick();
        chk("b2b.ready_c2", ready, 1'b0);
        tick();
        chk("b2b.ready_c3", ready, 1'b0);
        chk("b2b.done1", done, 1'b1);
        chk("b2b.addr1", wb_addr, 3'd4);
        chk("b2b.data1", wb_data, 8'h11);
        tick();
        chk("b2b.ready_c4", ready, 1'b1);
        dbg_chk("b2b.r4", 3'd4, 8'h11);
        tick();
        valid = 1'b0;
        chk("b2b.ready_c5", ready, 1'b0);
        tick();
        chk("b2b.s1_c6", alu_s1, 8'h11);
        chk("b2b.done_c6", done, 1'b0);
        tick();
        chk("b2b.done2", done, 1'b1);
        chk("b2b.we2", wb_we, 1'b1);
        chk("b2b.addr2", wb_addr, 3'd5);
        chk("b2b.data2", wb_data, 8'h22);
        tick();
        dbg_chk("b2b.r5", 3'd5, 8'h22);
        chk("b2b.flags", flags, 3'b000);

        // Reset mid-FETCH
        load("rst2.ld1", 3'd1, 8'h05);
        load("rst2.ld2", 3'd2, 8'h80);
        chk("rst2.pre_flags", flags, 3'b010);
        dbg_chk("rst2.pre_r1", 3'd1, 8'h05);
        drive(FUNC_ADD, 3'd3, 3'd1, 3'd1, 1'b0, 8'h00);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("rst2.in_fetch", ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst2.flags", flags, 3'b000);
        chk("rst2.ready", ready, 1'b1);
        chk("rst2.done", done, 1'b0);
        dbg_chk("rst2.r1", 3'd1, 8'h00);
        dbg_chk("rst2.r2", 3'd2, 8'h00);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("rst2.no_done", done_cnt, 0);
        dbg_chk("rst2.r3", 3'd3, 8'h00);
        chk("rst2.post_flags", flags, 3'b000);
        chk("rst2.post_ready", ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
